// File: rtl/demux7_pkg.sv
// demux7_pkg: shared sign-magnitude constants and lane-state type for demux7_stream
package demux7_pkg;
    localparam int SM_W        = 7;
    localparam int SM_SIGN_BIT = 6;
    localparam logic [SM_W-1:0] SM_NEG_ZERO = 7'b1000000;

    typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_e;

    function automatic logic is_neg_zero(input logic [SM_W-1:0] w);
        return w[SM_SIGN_BIT] && (w[SM_SIGN_BIT-1:0] == '0);
    endfunction
endpackage

// File: rtl/demux7_stream_if.sv
// demux7_stream_if: input stream, two output lanes and per-lane transfer counters
interface demux7_stream_if #(
    parameter int W     = 7,
    parameter int CNT_W = 8
);
    logic             select;
    logic [W-1:0]     a;
    logic             a_valid;
    logic             a_ready;
    logic [W-1:0]     b0;
    logic             b0_valid;
    logic             b0_ready;
    logic [W-1:0]     b1;
    logic             b1_valid;
    logic             b1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output select, a, a_valid, b0_ready, b1_ready,
        input  a_ready, b0, b0_valid, b1, b1_valid, cnt0, cnt1
    );

    modport slave (
        input  select, a, a_valid, b0_ready, b1_ready,
        output a_ready, b0, b0_valid, b1, b1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux7_lane.sv
// demux7_lane: one-entry holding register with EMPTY/FULL state machine and pop counter
module demux7_lane
    import demux7_pkg::*;
#(
    parameter int W     = SM_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             ready_i,
    output logic [W-1:0]     data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);
    lane_state_e      state_q, state_d;
    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign pop = valid_o & ready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= LANE_EMPTY;
        else        state_q <= state_d;

    // A push always leaves the lane full; a pop without push empties it
    always_comb state_d = push_i ? LANE_FULL : (pop ? LANE_EMPTY : state_q);

    // Outputs decoded from the registered state
    always_comb begin
        valid_o = (state_q == LANE_FULL);
        data_o  = data_q;
        cnt_o   = cnt_q;
    end

    // Holding register loads on every push, including push during pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      data_q <= '0;
        else if (push_i) data_q <= data_i;

    // Completed-transfer counter, wraps silently
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + CNT_W'(1);
endmodule

// File: rtl/demux7_stream.sv
// demux7_stream: routes one sign-magnitude stream to two buffered lanes (optional SM_NEGZERO_NORM_EN)
module demux7_stream
    import demux7_pkg::*;
#(
    parameter int W     = SM_W,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    demux7_stream_if.slave      bus
);
    logic [W-1:0] data_n;
    logic         push0, push1;

    // Only the selected lane can stall the input
    always_comb begin
        bus.a_ready = bus.select ? (!bus.b1_valid | bus.b1_ready) : (!bus.b0_valid | bus.b0_ready);
        push0       = bus.a_valid & bus.a_ready & !bus.select;
        push1       = bus.a_valid & bus.a_ready &  bus.select;
    end

`ifdef SM_NEGZERO_NORM_EN
    assign data_n = is_neg_zero(bus.a) ? '0 : bus.a;
`else
    assign data_n = bus.a;
`endif

    demux7_lane #(.W(W), .CNT_W(CNT_W)) u_lane0 (
        .clk(clk), .rst_n(rst_n), .push_i(push0), .data_i(data_n), .ready_i(bus.b0_ready),
        .data_o(bus.b0), .valid_o(bus.b0_valid), .cnt_o(bus.cnt0)
    );

    demux7_lane #(.W(W), .CNT_W(CNT_W)) u_lane1 (
        .clk(clk), .rst_n(rst_n), .push_i(push1), .data_i(data_n), .ready_i(bus.b1_ready),
        .data_o(bus.b1), .valid_o(bus.b1_valid), .cnt_o(bus.cnt1)
    );
endmodule

// File: tb/tb_demux7_stream.sv
// tb_demux7_stream: directed and random checks of demux7_stream against a queue model
module tb_demux7_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [6:0] q0[$];
    logic [6:0] q1[$];
    int   c0 = 0;
    int   c1 = 0;
    logic last_acc = 1'b0;
    int   s;
    logic [6:0] exp_nz;

    demux7_stream_if #(.W(7), .CNT_W(8)) bus();
    demux7_stream dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [6:0] norm(input logic [6:0] w);
`ifdef SM_NEGZERO_NORM_EN
        return (w == 7'h40) ? 7'h00 : w;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [6:0] d, input logic r0, input logic r1);
        bus.a_valid  = v;
        bus.select   = sel;
        bus.a        = d;
        bus.b0_ready = r0;
        bus.b1_ready = r1;
        #1;
    endtask

    task automatic check_outs();
        chk("b0_valid", bus.b0_valid, q0.size() != 0);
        chk("b1_valid", bus.b1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("b0_data", bus.b0, q0[0]);
        if (q1.size() != 0) chk("b1_data", bus.b1, q1[0]);
        chk("cnt0", bus.cnt0, c0);
        chk("cnt1", bus.cnt1, c1);
    endtask

    // Each lane behaves as a one-deep FIFO: ready when empty or being drained
    task automatic cycle();
        logic exp_rdy, acc, p0, p1;
        #2;
        exp_rdy = bus.select ? (q1.size() == 0 || bus.b1_ready) : (q0.size() == 0 || bus.b0_ready);
        chk("a_ready", bus.a_ready, exp_rdy);
        acc = bus.a_valid && exp_rdy;
        p0  = q0.size() != 0 && bus.b0_ready;
        p1  = q1.size() != 0 && bus.b1_ready;
        @(posedge clk);
        #1;
        if (p0) begin void'(q0.pop_front()); c0 = (c0 + 1) % 256; end
        if (p1) begin void'(q1.pop_front()); c1 = (c1 + 1) % 256; end
        if (acc) begin
            if (bus.select) q1.push_back(norm(bus.a));
            else            q0.push_back(norm(bus.a));
        end
        last_acc = acc;
        check_outs();
    endtask

    initial begin
        drive(1'b1, 1'b0, 7'h33, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        chk("rst_b0", bus.b0, 0);
        chk("rst_b1", bus.b1, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        chk("rst_a_ready", bus.a_ready, 1);

        drive(1'b1, 1'b0, 7'b1010101, 1'b1, 1'b1);
        cycle();
        chk("route_b0", bus.b0, 7'b1010101);
        drive(1'b1, 1'b1, 7'b0101000, 1'b1, 1'b1);
        cycle();
        chk("route_b1", bus.b1, 7'b0101000);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        chk("route_cnt0", bus.cnt0, 1);
        chk("route_cnt1", bus.cnt1, 1);

        drive(1'b1, 1'b0, 7'h55, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 7'h2A, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("bp_a_ready", bus.a_ready, 0);
        chk("bp_hold_b0", bus.b0, 7'h55);
        drive(1'b1, 1'b1, 7'h11, 1'b0, 1'b1);
        chk("bp_other_ready", bus.a_ready, 1);
        cycle();
        chk("bp_b1", bus.b1, 7'h11);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 7'h2A, 1'b1, 1'b1);
        cycle();
        chk("bp_order", bus.b0, 7'h2A);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        chk("bp_cnt0", bus.cnt0, 3);

        s = c1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 7'(i), 1'b1, 1'b1);
            cycle();
            chk("stream_b1", bus.b1, i);
        end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        chk("stream_cnt1", bus.cnt1, (s + 10) % 256);

        repeat (300) begin
            if (bus.a_valid && !last_acc)
                drive(1'b1, bus.select, bus.a, ($urandom_range(3) != 0), ($urandom_range(3) != 0));
            else
                drive(($urandom_range(3) != 0), 1'($urandom), 7'($urandom),
                      ($urandom_range(3) != 0), ($urandom_range(3) != 0));
            cycle();
        end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        cycle();

        s = c0;
        repeat (256) begin
            drive(1'b1, 1'b0, 7'($urandom), 1'b1, 1'b1);
            cycle();
        end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();
        chk("wrap_cnt0", bus.cnt0, s);

`ifdef SM_NEGZERO_NORM_EN
        exp_nz = 7'b0000000;
`else
        exp_nz = 7'b1000000;
`endif
        drive(1'b1, 1'b0, 7'b1000000, 1'b0, 1'b1);
        cycle();
        chk("negzero", bus.b0, exp_nz);
        drive(1'b1, 1'b0, 7'b1000001, 1'b1, 1'b1);
        cycle();
        chk("negzero_adj", bus.b0, 7'b1000001);

        drive(1'b0, 1'b0, 7'h00, 1'b0, 1'b1);
        chk("arst_pre_valid", bus.b0_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_b0_valid", bus.b0_valid, 0);
        chk("arst_cnt0", bus.cnt0, 0);
        chk("arst_cnt1", bus.cnt1, 0);
        chk("arst_b0", bus.b0, 0);
        q0.delete();
        q1.delete();
        c0 = 0;
        c1 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b1, 7'h22, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
